// File: rtl/synch_mod_counter_pkg.sv
// Shared definitions for the modulo-N counter: saturate-mode encodings and a
// helper that sizes the counter width from a modulus.
package synch_mod_counter_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } sat_mode_e;

    localparam int DEFAULT_WIDTH = 4;

    // Smallest width able to hold 0..mod-1; never narrower than one bit.
    function automatic int width_from_mod(input int mod);
        return (mod <= 2) ? 1 : $clog2(mod);
    endfunction

endpackage

// File: rtl/synch_mod_counter_if.sv
// Control and status bundle of the modulo-N counter; the master drives the
// controls, the counter (slave) returns the count and terminal-count pulse.
interface synch_mod_counter_if #(
    parameter int n = 4
);
    logic         en;
    logic         up;
    logic         load;
    logic [n-1:0] d;
    logic [n-1:0] Q;
    logic         tc;

    modport master (output en, output up, output load, output d,
                    input  Q,  input  tc);
    modport slave  (input  en, input  up, input  load, input  d,
                    output Q,  output tc);
endinterface

// File: rtl/synch_mod_counter.sv
// Synchronous modulo-MOD up/down counter with clamped parallel load,
// wrap or saturate at the limits, and a registered terminal-count pulse.
module synch_mod_counter
    import synch_mod_counter_pkg::*;
#(
    parameter int        n        = DEFAULT_WIDTH,
    parameter int        MOD      = 2 ** n,
    parameter sat_mode_e SATURATE = WRAP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    synch_mod_counter_if.slave    bus
);

    localparam logic [n-1:0] MAX = n'(MOD - 1);
    localparam logic [n-1:0] ONE = n'(1);

    if ((MOD < 2) || (MOD > (2 ** n))) begin : g_bad_mod
        $fatal(1, "synch_mod_counter: MOD=%0d outside 2..2**n", MOD);
    end

    logic [n-1:0] count_q, count_d;
    logic         tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = (bus.d > MAX) ? MAX : bus.d;
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_q == MAX) begin
                    // Limit event: the pulse fires whether we wrap or hold.
                    tc_d    = 1'b1;
                    count_d = (SATURATE == SAT) ? MAX : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE == SAT) ? '0 : MAX;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.Q  = count_q;
    assign bus.tc = tc_q;

endmodule

// File: tb/tb_synch_mod_counter.sv
// Drives three counters (MOD=10 wrap, MOD=10 saturate, MOD=16 wrap) with one
// shared stimulus and checks them against an arithmetic model every cycle.
module tb_synch_mod_counter;
    import synch_mod_counter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    synch_mod_counter_if #(.n(4)) ifa ();
    synch_mod_counter_if #(.n(4)) ifb ();
    synch_mod_counter_if #(.n(4)) ifc ();

    synch_mod_counter #(.n(4), .MOD(10), .SATURATE(WRAP)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    synch_mod_counter #(.n(4), .MOD(10), .SATURATE(SAT)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));
    synch_mod_counter #(.n(4), .MOD(16), .SATURATE(WRAP)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int mods[3] = '{10, 10, 16};
    bit sats[3] = '{1'b0, 1'b1, 1'b0};
    int mq[3]   = '{0, 0, 0};
    int mt[3]   = '{0, 0, 0};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit e, input bit u, input bit l, input int dv);
        ifa.en = e;  ifb.en = e;  ifc.en = e;
        ifa.up = u;  ifb.up = u;  ifc.up = u;
        ifa.load = l; ifb.load = l; ifc.load = l;
        ifa.d = 4'(dv); ifb.d = 4'(dv); ifc.d = 4'(dv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle; release lands on a falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_q_a", int'(ifa.Q), 0);
        chk("rst_tc_a", int'(ifa.tc), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Reference model: plain modular / clamped arithmetic on integers.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin mq[i] = 0; mt[i] = 0; end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int mx;
                mx = mods[i] - 1;
                if (ifa.load) begin
                    mq[i] = (int'(ifa.d) > mx) ? mx : int'(ifa.d);
                    mt[i] = 0;
                end else if (ifa.en && ifa.up) begin
                    mt[i] = (mq[i] + 1 > mx) ? 1 : 0;
                    mq[i] = sats[i] ? ((mq[i] + 1 > mx) ? mx : mq[i] + 1)
                                    : (mq[i] + 1) % mods[i];
                end else if (ifa.en) begin
                    mt[i] = (mq[i] - 1 < 0) ? 1 : 0;
                    mq[i] = sats[i] ? ((mq[i] - 1 < 0) ? 0 : mq[i] - 1)
                                    : (mq[i] + mods[i] - 1) % mods[i];
                end else begin
                    mt[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q_a", int'(ifa.Q), mq[0]);
            chk("model_tc_a", int'(ifa.tc), mt[0]);
            chk("model_q_b", int'(ifb.Q), mq[1]);
            chk("model_tc_b", int'(ifb.tc), mt[1]);
            chk("model_q_c", int'(ifc.Q), mq[2]);
            chk("model_tc_c", int'(ifc.tc), mt[2]);
        end
    end

    int wrap_q[11]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int wrap_tc[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int sat_tc[4]   = '{0, 1, 1, 1};

    initial begin
        reset_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_q_a", int'(ifa.Q), 0);
        chk("async_rst_tc_a", int'(ifa.tc), 0);
        chk("async_rst_q_b", int'(ifb.Q), 0);
        chk("async_rst_q_c", int'(ifc.Q), 0);
        chk_en = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 0);
        tick();
        tick();
        chk("rst_hold_q_a", int'(ifa.Q), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("post_rst_step_a", int'(ifa.Q), i);
        end

        // Up count through the wrap
        do_reset();
        for (int i = 0; i < 11; i++) begin
            tick();
            $display("up_wrap step %0d: Q=%0d tc=%0d", i, ifa.Q, ifa.tc);
            chk("up_wrap_q_a", int'(ifa.Q), wrap_q[i]);
            chk("up_wrap_tc_a", int'(ifa.tc), wrap_tc[i]);
        end

        // Down count wraps from 0 to MAX
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 0);
        tick(); chk("down_q0", int'(ifa.Q), 9); chk("down_tc0", int'(ifa.tc), 1);
        tick(); chk("down_q1", int'(ifa.Q), 8); chk("down_tc1", int'(ifa.tc), 0);
        tick(); chk("down_q2", int'(ifa.Q), 7); chk("down_tc2", int'(ifa.tc), 0);
        do_reset();
        tick(); chk("pend_tc_set", int'(ifa.tc), 1);
        reset_n = 1'b0;
        #1;
        chk("pend_tc_cleared", int'(ifa.tc), 0);
        chk("pend_q_cleared", int'(ifa.Q), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Saturating instance holds at MAX and re-pulses tc
        set_in(1'b0, 1'b1, 1'b1, 8);
        tick(); chk("sat_load_b", int'(ifb.Q), 8);
        set_in(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("saturate step %0d: Q=%0d tc=%0d", i, ifb.Q, ifb.tc);
            chk("sat_q_b", int'(ifb.Q), 9);
            chk("sat_tc_b", int'(ifb.tc), sat_tc[i]);
        end
        set_in(1'b1, 1'b0, 1'b0, 0);
        tick(); chk("sat_down_q_b", int'(ifb.Q), 8); chk("sat_down_tc_b", int'(ifb.tc), 0);

        // Load priority and clamping
        set_in(1'b1, 1'b1, 1'b1, 7);
        tick(); chk("load7_q_a", int'(ifa.Q), 7); chk("load7_tc_a", int'(ifa.tc), 0);
        set_in(1'b1, 1'b1, 1'b1, 12);
        tick(); chk("load12_clamp_a", int'(ifa.Q), 9); chk("load12_c", int'(ifc.Q), 12);
        set_in(1'b1, 1'b1, 1'b1, 9);
        tick(); chk("load_at_max_q_a", int'(ifa.Q), 9); chk("load_at_max_tc_a", int'(ifa.tc), 0);
        chk("load_at_max_tc_b", int'(ifb.tc), 0);
        set_in(1'b1, 1'b0, 1'b0, 0);
        tick(); chk("dir_change_q_a", int'(ifa.Q), 8); chk("dir_change_tc_a", int'(ifa.tc), 0);

        // Hold with en low while up and d wander
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, i[0], 1'b0, int'($urandom_range(0, 15)));
            tick();
            chk("hold_q_a", int'(ifa.Q), 8);
            chk("hold_tc_a", int'(ifa.tc), 0);
        end

        // Full-range modulus behaves as a free-running 4-bit counter
        set_in(1'b0, 1'b1, 1'b1, 15);
        tick(); chk("full_load_c", int'(ifc.Q), 15);
        set_in(1'b1, 1'b1, 1'b0, 0);
        tick(); chk("full_wrap_q_c", int'(ifc.Q), 0); chk("full_wrap_tc_c", int'(ifc.tc), 1);
        tick(); chk("full_next_q_c", int'(ifc.Q), 1); chk("full_next_tc_c", int'(ifc.tc), 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
